// File: rtl/mdu_issue_ctrl_if.sv
// Bundle between the E-stage issue point, the issue controller and the MDU.
// The request is consumed in any cycle where req_valid && req_ready; a stalled request is held by the pipeline.
interface mdu_issue_ctrl_if;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        Req;
  logic        req_ready;
  logic        stall;
  logic        mdu_start;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        mdu_busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, Req, mdu_busy,
    output req_ready, stall, mdu_start, mdu_op, mdu_a, mdu_b
  );

  modport master (
    output req_valid, req_op, req_a, req_b, Req, mdu_busy,
    input  req_ready, stall, mdu_start, mdu_op, mdu_a, mdu_b
  );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: start/op/operand generation,
// busy stall, exception suppression, hung-unit watchdog and issue/stall statistics.
module mdu_issue_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  mdu_issue_ctrl_if.slave  bus,
  output logic             err_timeout,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_dbg
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              err_nxt;

  logic op_start, op_nop, free, take, stall_i, start_i, issue_i;

  // Request decode; everything is gated by reset so the outputs read 0 while it is held low.
  always_comb begin
    op_start = (bus.req_op >= 4'd1) && (bus.req_op <= 4'd4);
    op_nop   = !((bus.req_op >= 4'd1) && (bus.req_op <= 4'd8));
    free     = ((state == IDLE) || (state == WAIT)) && !bus.mdu_busy;
    take     = reset && bus.req_valid && !op_nop && !bus.Req;
    stall_i  = take && !free;
    issue_i  = take && free;
    start_i  = issue_i && op_start;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      err_timeout <= err_nxt;
    end
  end

  // The watchdog counts LAUNCH plus every busy WAIT cycle; a start out of WAIT rearms it.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    err_nxt   = err_timeout;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = LAUNCH;
          wcnt_nxt  = '0;
        end
      end
      LAUNCH: begin
        state_nxt = WAIT;
        wcnt_nxt  = wcnt + 1'b1;
      end
      WAIT: begin
        if (!bus.mdu_busy) begin
          if (start_i) begin
            state_nxt = LAUNCH;
            wcnt_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (wcnt == WCNT_W'(MAX_WAIT)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.stall     = stall_i;
    bus.req_ready = reset && !stall_i;
    bus.mdu_start = start_i;
    bus.mdu_op    = issue_i ? bus.req_op : 4'd0;
    bus.mdu_a     = issue_i ? bus.req_a : 32'd0;
    bus.mdu_b     = issue_i ? bus.req_b : 32'd0;
    state_dbg     = state;
  end

  // Issue count wraps; stall count saturates so long runs stay meaningful.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (start_i) issue_cnt <= issue_cnt + 1'b1;
      if (stall_i && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: directed scenarios plus random traffic against a cycle-level
// reference model, with a small MDU stand-in that raises busy after each start.
module tb_mdu_issue_ctrl;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 6;
  localparam int CNT_TOP  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mdu_issue_ctrl_if bus();
  logic             err_timeout;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state_dbg;

  mdu_issue_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err_timeout (err_timeout),
    .issue_cnt   (issue_cnt),
    .stall_cnt   (stall_cnt),
    .state_dbg   (state_dbg)
  );

  typedef struct packed {
    logic             ready;
    logic             stall;
    logic             start;
    logic [3:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             err;
    logic [CNT_W-1:0] icnt;
    logic [CNT_W-1:0] scnt;
    logic [1:0]       st;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: "launched" is the cycle after an issue; wait_k numbers busy cycles after that.
  bit m_launched;
  int m_wait_k;
  bit m_err;
  int m_icnt;
  int m_scnt;

  // MDU stand-in.
  int busy_left;
  bit hang;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("req_ready",   32'(bus.req_ready), 32'(e.ready));
        check("stall",       32'(bus.stall),     32'(e.stall));
        check("mdu_start",   32'(bus.mdu_start), 32'(e.start));
        check("mdu_op",      32'(bus.mdu_op),    32'(e.op));
        check("mdu_a",       bus.mdu_a,          e.a);
        check("mdu_b",       bus.mdu_b,          e.b);
        check("err_timeout", 32'(err_timeout),   32'(e.err));
        check("issue_cnt",   32'(issue_cnt),     32'(e.icnt));
        check("stall_cnt",   32'(stall_cnt),     32'(e.scnt));
        check("state",       32'(state_dbg),     32'(e.st));
      end
    end
  end

  // One clock cycle of stimulus; entered and left just after a rising edge.
  task automatic cycle(input bit v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit rq);
    exp_t e;
    bit   is_nop, is_start, free, busy, stl, st, iss;
    bit   start_seen;
    logic [3:0] op_seen;
    busy = hang || (busy_left > 0);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.Req       = rq;
    bus.mdu_busy  = busy;

    is_nop   = !(op >= 1 && op <= 8);
    is_start = (op >= 1 && op <= 4);
    free     = !m_launched && !busy;
    stl      = v && !is_nop && !rq && !free;
    iss      = v && !is_nop && !rq && free;
    st       = iss && is_start;
    e.ready  = !stl;
    e.stall  = stl;
    e.start  = st;
    e.op     = iss ? op : 4'd0;
    e.a      = iss ? a : 32'd0;
    e.b      = iss ? b : 32'd0;
    e.err    = m_err;
    e.icnt   = CNT_W'(m_icnt);
    e.scnt   = CNT_W'(m_scnt);
    e.st     = m_launched ? 2'd1 : (m_wait_k > 0 ? 2'd2 : 2'd0);
    exp_q.push_back(e);

    @(negedge clk);
    start_seen = bus.mdu_start;
    op_seen    = bus.mdu_op;
    @(posedge clk);
    if (busy_left > 0) busy_left--;
    if (start_seen) busy_left = (op_seen <= 4'd2) ? 5 : 10;

    if (st) m_icnt = (m_icnt + 1) % (CNT_TOP + 1);
    if (stl && m_scnt < CNT_TOP) m_scnt++;
    if (m_launched) m_wait_k = 1;
    else if (m_wait_k > 0) begin
      if (!busy) m_wait_k = 0;
      else if (m_wait_k == MAX_WAIT) begin
        m_err    = 1'b1;
        m_wait_k = 0;
      end else m_wait_k++;
    end
    m_launched = st;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Reset dropped mid-cycle while a mult would otherwise be issuing.
  task automatic do_reset();
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd1;
    bus.req_a     = 32'h1234_5678;
    bus.req_b     = 32'h9abc_def0;
    bus.Req       = 1'b0;
    bus.mdu_busy  = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_stall",     32'(bus.stall),     32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_start",     32'(bus.mdu_start), 32'd0);
    check("rst_op",        32'(bus.mdu_op),    32'd0);
    check("rst_a",         bus.mdu_a,          32'd0);
    check("rst_b",         bus.mdu_b,          32'd0);
    check("rst_err",       32'(err_timeout),   32'd0);
    check("rst_issue_cnt", 32'(issue_cnt),     32'd0);
    check("rst_stall_cnt", 32'(stall_cnt),     32'd0);
    m_launched = 1'b0;
    m_wait_k   = 0;
    m_err      = 1'b0;
    m_icnt     = 0;
    m_scnt     = 0;
    busy_left  = 0;
    hang       = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_state", 32'(state_dbg), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.Req       = 1'b0;
    bus.mdu_busy  = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // mult, then a dependent mfhi held until accepted
    cycle(1'b1, 4'd1, 32'd7, 32'd9, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    idle(2);
    check("mult_mfhi_issue_cnt", 32'(issue_cnt), 32'd1);
    check("mult_mfhi_stall_cnt", 32'(stall_cnt), 32'd5);

    // div followed by a second div
    do_reset();
    cycle(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 11; i++) cycle(1'b1, 4'd3, 32'd50, 32'd3, 1'b0);
    idle(12);
    check("div_div_issue_cnt", 32'(issue_cnt), 32'd2);
    check("div_div_stall_cnt", 32'(stall_cnt), 32'd10);

    // flushed div and mtlo reach nothing
    cycle(1'b1, 4'd3, 32'd1, 32'd2, 1'b1);
    cycle(1'b1, 4'd8, 32'd3, 32'd4, 1'b1);
    idle(1);
    check("flush_issue_cnt", 32'(issue_cnt), 32'd2);

    // hung unit trips the watchdog; the error stays set after busy drops
    do_reset();
    cycle(1'b1, 4'd1, 32'd5, 32'd6, 1'b0);
    hang = 1'b1;
    idle(MAX_WAIT + 4);
    check("wd_err",   32'(err_timeout), 32'd1);
    check("wd_state", 32'(state_dbg),   32'd0);
    hang = 1'b0;
    idle(3);
    cycle(1'b1, 4'd2, 32'd11, 32'd12, 1'b0);
    idle(8);
    check("wd_sticky", 32'(err_timeout), 32'd1);

    // random traffic long enough to wrap issue_cnt and saturate stall_cnt
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom, $urandom,
            1'($urandom_range(0, 7) == 0));
    end
    idle(12);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
# mdu_issue_ctrl

Issue-side controller for the E-stage multiply/divide unit. It sits between the E-stage pipeline register and the MDU and converts MDU instructions into the MDU's `Start`/op/operand interface. It generates the pipeline stall while the unit is busy, suppresses issue when an exception request is raised, and watches for a hung unit. It also keeps issue and stall statistics for the performance counters.

## Interface
Parameters:
- `MAX_WAIT`, 15: watchdog limit in cycles for one multiply/divide (must exceed 10, the longest MDU latency).
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; 0 resets immediately, independent of `clk`.
- `req_valid` in 1: E stage holds a valid MDU instruction.
- `req_op` in 4: MDU op code. 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 are treated as nop.
- `req_a`, `req_b` in 32: rs and rt operands.
- `Req` in 1: exception/interrupt request; the E-stage instruction is being flushed.
- `req_ready` out 1: the instruction is consumed this cycle (`= !stall`).
- `stall` out 1: freeze F/D/E this cycle.
- `mdu_start` out 1: one-cycle start pulse to the MDU.
- `mdu_op` out 4: op presented to the MDU.
- `mdu_a`, `mdu_b` out 32: operands presented to the MDU.
- `mdu_busy` in 1: MDU Busy flag.
- `err_timeout` out 1: sticky watchdog error.
- `issue_cnt` out `CNT_W`: number of start ops issued; wraps.
- `stall_cnt` out `CNT_W`: number of stall cycles; saturates.

## Operation
- Op classes: start ops are 1–4; access ops are 5–8; nop is 0 and 9–15.
- FSM states: IDLE, LAUNCH, WAIT. The watchdog counter `wcnt` has width ceil(log2(MAX_WAIT+1)).
- `free = (state==IDLE || state==WAIT) && !mdu_busy`.
- `stall = req_valid && op!=nop && !Req && !free`. Nops and flushed instructions never stall.
- `mdu_start = req_valid && start-op && free && !Req`.
- `mdu_op`:
  - equals `req_op` when `req_valid && op!=nop && free && !Req`;
  - otherwise 0.
  - With `Req`, mthi/mtlo therefore never reach the MDU.
- `mdu_a`/`mdu_b` equal `req_a`/`req_b` when `mdu_op!=0`, otherwise 0. All MDU-side outputs are combinational.
- Transitions:
  - IDLE→LAUNCH on `mdu_start`, clearing `wcnt`.
  - LAUNCH→WAIT unconditionally; `wcnt` increments.
  - WAIT→IDLE when `!mdu_busy`, unless `mdu_start` is asserted that cycle, in which case WAIT→LAUNCH.
  - In WAIT with `mdu_busy`, `wcnt` increments. When `wcnt==MAX_WAIT`, set `err_timeout` and go to IDLE.
- `err_timeout` is cleared only by reset.
- `issue_cnt` increments on every `mdu_start` and wraps from all-ones to 0.
- `stall_cnt` increments on every cycle where `stall=1` and holds at all-ones.
- Reset value of every output: 0. Reset value of the state is IDLE; `wcnt` and both counters reset to 0.
- While `reset` is low, all combinational outputs are forced to 0.
- Reset asserted mid-WAIT returns to IDLE immediately. The MDU is reset by the same domain.
- `Req` during LAUNCH/WAIT does not abort the in-flight operation; the MDU completes it.

## Timing
- A start op issues in cycle N with zero stall.
- In cycle N+1 the state is LAUNCH and `mdu_busy`=1.
- `mdu_busy` stays high for 5 cycles for mult/multu (N+1..N+5) and 10 cycles for div/divu (N+1..N+10).
- A dependent MDU instruction arriving at N+1 stalls 5 cycles for mult or 10 cycles for div, and is accepted at N+6 or N+11 respectively.
- mfhi/mflo data is valid from the MDU in the same cycle they are accepted.
- mthi/mtlo take effect at the end of the accept cycle.
- Back-to-back start ops: the second issues in the first cycle where `mdu_busy`=0 (WAIT→LAUNCH).

## Test plan
- Reset: drive `reset`=0 mid-cycle with `req_valid`=1, op=1 → all outputs 0 immediately. After release, state is IDLE and both counters are 0.
- mult then mfhi: mult issues at cycle 0 with `mdu_start`=1. mfhi presented at cycles 1–6 → `stall`=1 for cycles 1–5; at cycle 6 `mdu_op`=5 and `req_ready`=1. `issue_cnt`=1, `stall_cnt`=5.
- div then div: the second div stalls 10 cycles, then `mdu_start`=1 at cycle 11 with WAIT→LAUNCH; `issue_cnt`=2.
- Req flush: div with `Req`=1 → `mdu_start`=0, `mdu_op`=0, `stall`=0, `issue_cnt` unchanged. mtlo with `Req`=1 → `mdu_op`=0.
- Watchdog: start mult, then hold `mdu_busy`=1 → `err_timeout`=1 after `MAX_WAIT` WAIT cycles, state IDLE. It stays 1 until reset.
- Counter edges: preload `stall_cnt` to 0xFFFF and stall once → stays 0xFFFF. Preload `issue_cnt` to 0xFFFF and issue once → wraps to 0.
